// File: rtl/exe_pkg.sv
// Shared definitions for the execute-stage ALU: command encodings, NZCV flag indices and FSM states.
package exe_pkg;

    localparam int EXE_CMD_W = 4;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exe_state_t;

endpackage

// File: rtl/exe_alu_seq_if.sv
// Command/result bundle between the issue logic (master) and the execute-stage ALU (slave).
interface exe_alu_seq_if #(
    parameter int WIDTH = 32,
    parameter int CMD_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [CMD_W-1:0] exe_cmd;
    logic             s_en;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic [3:0]       status_in;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [3:0]       status_out;
    logic             status_load;
    logic             busy;

    modport master (
        output in_valid, exe_cmd, s_en, val1, val2, status_in,
        input  in_ready, out_valid, result, status_out, status_load, busy
    );

    modport slave (
        input  in_valid, exe_cmd, s_en, val1, val2, status_in,
        output in_ready, out_valid, result, status_out, status_load, busy
    );
endinterface

// File: rtl/exe_mul_seq.sv
// Shift-add multiplier producing the low WIDTH bits of a*b; one step per cycle for WIDTH cycles.
// Only instantiated when EXE_MUL_EN is defined.
module exe_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;

    // product is the accumulator after the step that the next edge performs
    assign product = acc + (mplier[0] ? mcand : '0);
    assign last    = (count == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= CNT_W'(WIDTH);
        end else if (count != '0) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/exe_alu_seq.sv
// Execute-stage ALU feeding the NZCV status register; single-cycle ops plus optional multi-cycle MUL.
// Macro EXE_MUL_EN builds the MUL command, its FSM state and the exe_mul_seq multiplier.
module exe_alu_seq
    import exe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CMD_W = EXE_CMD_W
) (
    input  logic             clk,
    input  logic             rst,
    exe_alu_seq_if.slave     bus
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   wide;
    logic             arith;
    logic             is_sub;
    logic             cin;
    logic             known;
    logic [3:0]       alu_flags;

    // Subtraction is a + ~b + cin so carry out is directly the NOT-borrow flag
    always_comb begin
        alu_res = '0;
        arith   = 1'b0;
        is_sub  = 1'b0;
        cin     = 1'b0;
        known   = 1'b1;
        case (bus.exe_cmd)
            CMD_W'(CMD_MOV): alu_res = bus.val2;
            CMD_W'(CMD_MVN): alu_res = ~bus.val2;
            CMD_W'(CMD_ADD): arith = 1'b1;
            CMD_W'(CMD_ADC): begin arith = 1'b1; cin = bus.status_in[FLAG_C]; end
            CMD_W'(CMD_SUB): begin arith = 1'b1; is_sub = 1'b1; cin = 1'b1; end
            CMD_W'(CMD_SBC): begin arith = 1'b1; is_sub = 1'b1; cin = bus.status_in[FLAG_C]; end
            CMD_W'(CMD_AND): alu_res = bus.val1 & bus.val2;
            CMD_W'(CMD_ORR): alu_res = bus.val1 | bus.val2;
            CMD_W'(CMD_EOR): alu_res = bus.val1 ^ bus.val2;
            default:         known = 1'b0;
        endcase
        b_eff = is_sub ? ~bus.val2 : bus.val2;
        wide  = {1'b0, bus.val1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        if (arith) begin
            alu_res = wide[MSB:0];
        end
        alu_flags = bus.status_in;
        if (known) begin
            alu_flags[FLAG_N] = alu_res[MSB];
            alu_flags[FLAG_Z] = (alu_res == '0);
            if (arith) begin
                alu_flags[FLAG_C] = wide[WIDTH];
                alu_flags[FLAG_V] = (bus.val1[MSB] == b_eff[MSB]) && (alu_res[MSB] != bus.val1[MSB]);
            end
        end
    end

`ifdef EXE_MUL_EN
    exe_state_t       state;
    logic             in_ready_q;
    logic             mul_s_en;
    logic [1:0]       mul_cv;
    logic             mul_start;
    logic             mul_last;
    logic [WIDTH-1:0] mul_product;

    assign mul_start    = bus.in_valid && (state == ST_IDLE) && (bus.exe_cmd == CMD_W'(CMD_MUL));
    assign bus.in_ready = in_ready_q;

    exe_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.val1),
        .b       (bus.val2),
        .last    (mul_last),
        .product (mul_product)
    );
`else
    assign bus.in_ready = 1'b1;
`endif

    assign bus.busy = ~bus.in_ready;

    // Registered outputs; out_valid and status_load are single-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.result      <= '0;
            bus.status_out  <= '0;
            bus.status_load <= 1'b0;
`ifdef EXE_MUL_EN
            state      <= ST_IDLE;
            in_ready_q <= 1'b1;
            mul_s_en   <= 1'b0;
            mul_cv     <= '0;
`endif
        end else begin
            bus.out_valid   <= 1'b0;
            bus.status_load <= 1'b0;
`ifdef EXE_MUL_EN
            if (state == ST_MUL) begin
                if (mul_last) begin
                    bus.result      <= mul_product;
                    bus.status_out  <= {mul_product[MSB], (mul_product == '0), mul_cv};
                    bus.out_valid   <= 1'b1;
                    bus.status_load <= mul_s_en;
                    in_ready_q      <= 1'b1;
                    state           <= ST_IDLE;
                end
            end else if (mul_start) begin
                mul_s_en   <= bus.s_en;
                mul_cv     <= bus.status_in[FLAG_C:FLAG_V];
                in_ready_q <= 1'b0;
                state      <= ST_MUL;
            end else if (bus.in_valid) begin
`else
            if (bus.in_valid) begin
`endif
                bus.result      <= alu_res;
                bus.status_out  <= alu_flags;
                bus.out_valid   <= 1'b1;
                bus.status_load <= bus.s_en;
            end
        end
    end

endmodule
